// File: rtl/lockin_pkg.sv
// Shared lock-in/modulator definitions: FSM state type, Q-format width helpers
// and the signed saturation used wherever a wide value is cast to a narrower Q1 format.
package lockin_pkg;

    typedef enum logic [1:0] {
        OFF,
        RAMP,
        ON,
        RAMP_DOWN
    } lockin_state_t;

    // One guard bit above the Q2 product keeps the two-term sum from wrapping.
    localparam int ACC_GUARD_BITS = 1;

    function automatic int frac_bits(input int width);
        return width - 1;
    endfunction

    function automatic int dropped_bits(input int a_bits, input int b_bits, input int out_bits);
        return frac_bits(a_bits) + frac_bits(b_bits) - frac_bits(out_bits);
    endfunction

    function automatic logic signed [63:0] sat_signed(input logic signed [63:0] value,
                                                      input int bits);
        logic signed [63:0] max_v;
        logic signed [63:0] min_v;
        max_v = (64'sd1 <<< (bits - 1)) - 64'sd1;
        min_v = -(64'sd1 <<< (bits - 1));
        if (value > max_v) begin
            return max_v;
        end
        if (value < min_v) begin
            return min_v;
        end
        return value;
    endfunction

endpackage

// File: rtl/amp_slew.sv
// Per-channel amplitude slew limiter: on each tick cur moves toward target by at
// most step (step = 0 snaps). at_target reflects the value cur takes at this tick.
module amp_slew
    import lockin_pkg::*;
#(
    parameter int AMP_BITS = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                tick,
    input  logic [AMP_BITS-1:0] target,
    input  logic [AMP_BITS-2:0] step,
    output logic [AMP_BITS-1:0] cur,
    output logic                at_target
);

    logic signed [AMP_BITS:0] diff;
    logic        [AMP_BITS:0] mag;
    logic        [AMP_BITS:0] step_ext;
    logic [AMP_BITS-1:0]      cur_next;

    always_comb begin
        diff     = $signed({target[AMP_BITS-1], target}) - $signed({cur[AMP_BITS-1], cur});
        mag      = diff[AMP_BITS] ? -diff : diff;
        step_ext = {2'b00, step};
        cur_next = target;
        if ((step != '0) && (mag > step_ext)) begin
            cur_next = diff[AMP_BITS] ? (cur - {1'b0, step}) : (cur + {1'b0, step});
        end
        at_target = (cur_next == target);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cur <= '0;
        end else if (tick) begin
            cur <= cur_next;
        end
    end

endmodule

// File: rtl/iq_modulator.sv
// Quadrature modulator: signal_out = X_cur*cos_ref + Y_cur*sin_ref with slewed amplitudes,
// one shared multiplier at clk = 2*Fs. Define IQ_MODULATOR_ROUND_EN for round-half-up output.
module iq_modulator
    import lockin_pkg::*;
#(
    parameter int INPUT_BITS  = 16,
    parameter int AMP_BITS    = 16,
    parameter int OUTPUT_BITS = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    input  logic [AMP_BITS-1:0]    X_in,
    input  logic [AMP_BITS-1:0]    Y_in,
    input  logic [AMP_BITS-2:0]    ramp_step,
    input  logic [INPUT_BITS-1:0]  sin_ref,
    input  logic [INPUT_BITS-1:0]  cos_ref,
    input  logic                   in_valid,
    output logic [OUTPUT_BITS-1:0] signal_out,
    output logic                   out_valid,
    output logic                   sat,
    output logic                   active,
    output logic                   settled
);

    localparam int PROD_W = AMP_BITS + INPUT_BITS;
    localparam int ACC_W  = PROD_W + ACC_GUARD_BITS;
    localparam int DROP   = dropped_bits(AMP_BITS, INPUT_BITS, OUTPUT_BITS);

`ifdef IQ_MODULATOR_ROUND_EN
    localparam logic signed [ACC_W-1:0] RND_ADD = ACC_W'(1) <<< (DROP - 1);
`else
    localparam logic signed [ACC_W-1:0] RND_ADD = '0;
`endif

    logic                         phase;
    logic                         tick;
    logic [4:0]                   t_pipe;
    logic [AMP_BITS-1:0]          x_tgt, y_tgt;
    logic [AMP_BITS-1:0]          x_cur, y_cur;
    logic                         x_at, y_at;
    logic signed [INPUT_BITS-1:0] cos_r, sin_r;
    logic signed [AMP_BITS-1:0]   mul_a;
    logic signed [INPUT_BITS-1:0] mul_b;
    logic signed [PROD_W-1:0]     prod;
    logic signed [PROD_W-1:0]     acc_a;
    logic signed [ACC_W-1:0]      sum;
    logic signed [ACC_W-1:0]      rounded;
    logic signed [ACC_W-1:0]      shifted;
    logic signed [63:0]           sat_v;
    logic                         clipped;
    lockin_state_t                state, state_next;

    assign tick  = in_valid & ~phase;
    assign x_tgt = enable ? X_in : '0;
    assign y_tgt = enable ? Y_in : '0;

    amp_slew #(.AMP_BITS(AMP_BITS)) u_slew_x (
        .clk       (clk),
        .rst       (rst),
        .tick      (tick),
        .target    (x_tgt),
        .step      (ramp_step),
        .cur       (x_cur),
        .at_target (x_at)
    );

    amp_slew #(.AMP_BITS(AMP_BITS)) u_slew_y (
        .clk       (clk),
        .rst       (rst),
        .tick      (tick),
        .target    (y_tgt),
        .step      (ramp_step),
        .cur       (y_cur),
        .at_target (y_at)
    );

    // Decisions use the post-update amplitudes so a single-step ramp settles in one sample.
    always_comb begin
        state_next = state;
        if (tick) begin
            unique case (state)
                OFF:       if (enable) state_next = (x_at && y_at) ? ON : RAMP;
                RAMP:      if (!enable) state_next = (x_at && y_at) ? OFF : RAMP_DOWN;
                           else if (x_at && y_at) state_next = ON;
                ON:        if (!enable) state_next = (x_at && y_at) ? OFF : RAMP_DOWN;
                           else if (!(x_at && y_at)) state_next = RAMP;
                RAMP_DOWN: if (enable) state_next = (x_at && y_at) ? ON : RAMP;
                           else if (x_at && y_at) state_next = OFF;
                default:   state_next = OFF;
            endcase
        end
    end

    assign active  = (state != OFF);
    assign settled = (state == ON);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= OFF;
            phase  <= 1'b0;
            t_pipe <= '0;
            cos_r  <= '0;
            sin_r  <= '0;
        end else begin
            state  <= state_next;
            phase  <= in_valid ? ~phase : 1'b0;
            t_pipe <= {t_pipe[3:0], tick};
            if (tick) begin
                cos_r <= cos_ref;
                sin_r <= sin_ref;
            end
        end
    end

    // Cycle A (t_pipe[0]) multiplies X by cos, the following cycle Y by sin.
    assign mul_a = t_pipe[0] ? x_cur : y_cur;
    assign mul_b = t_pipe[0] ? cos_r : sin_r;

    always_comb begin
        rounded = sum + RND_ADD;
        shifted = rounded >>> DROP;
        sat_v   = sat_signed(64'(shifted), OUTPUT_BITS);
        clipped = (sat_v != 64'(shifted));
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            prod       <= '0;
            acc_a      <= '0;
            sum        <= '0;
            signal_out <= '0;
            sat        <= 1'b0;
            out_valid  <= 1'b0;
        end else begin
            prod      <= PROD_W'(mul_a) * PROD_W'(mul_b);
            out_valid <= t_pipe[3] | t_pipe[4];
            if (t_pipe[1]) begin
                acc_a <= prod;
            end
            if (t_pipe[2]) begin
                sum <= ACC_W'(acc_a) + ACC_W'(prod);
            end
            if (t_pipe[3]) begin
                signal_out <= sat_v[OUTPUT_BITS-1:0];
                sat        <= clipped;
            end
        end
    end

endmodule

// File: tb/tb_iq_modulator.sv
// Scoreboard bench for iq_modulator: directed samples push hand-computed outputs,
// a negedge monitor pops and compares each 2-clk output sample including its latency.
module tb_iq_modulator;

    localparam int IB = 16;
    localparam int AB = 16;
    localparam int OB = 16;
`ifdef IQ_MODULATOR_ROUND_EN
    localparam int RND = 1;
`else
    localparam int RND = 0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          enable = 1'b0;
    logic [AB-1:0] X_in = '0;
    logic [AB-1:0] Y_in = '0;
    logic [AB-2:0] ramp_step = '0;
    logic [IB-1:0] sin_ref = '0;
    logic [IB-1:0] cos_ref = '0;
    logic          in_valid = 1'b0;
    logic [OB-1:0] signal_out;
    logic          out_valid;
    logic          sat;
    logic          active;
    logic          settled;

    iq_modulator #(.INPUT_BITS(IB), .AMP_BITS(AB), .OUTPUT_BITS(OB)) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .X_in       (X_in),
        .Y_in       (Y_in),
        .ramp_step  (ramp_step),
        .sin_ref    (sin_ref),
        .cos_ref    (cos_ref),
        .in_valid   (in_valid),
        .signal_out (signal_out),
        .out_valid  (out_valid),
        .sat        (sat),
        .active     (active),
        .settled    (settled)
    );

    always #5 clk = ~clk;

    typedef struct {
        int     value;
        int     sat_flag;
        longint tick_time;
    } exp_t;

    exp_t sb[$];
    int   check_count = 0;
    int   pass_count  = 0;

    task automatic checkOutput(input string name, input int actual, input int expected);
        check_count++;
        if (actual == expected) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Drives one Fs sample (two clk with in_valid high); the first posedge is the tick.
    task automatic applyStimulus(input int x, input int y, input int c, input int s,
                                 input bit en, input int step,
                                 input int exp_out, input int exp_sat, input bit push);
        exp_t e;
        @(negedge clk);
        X_in      = AB'(x);
        Y_in      = AB'(y);
        cos_ref   = IB'(c);
        sin_ref   = IB'(s);
        enable    = en;
        ramp_step = (AB-1)'(step);
        in_valid  = 1'b1;
        @(posedge clk);
        e.value     = exp_out;
        e.sat_flag  = exp_sat;
        e.tick_time = longint'($time);
        if (push) sb.push_back(e);
        @(negedge clk);
        @(posedge clk);
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    bit   second   = 1'b0;
    bit   have_exp = 1'b0;
    exp_t cur_exp;

    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            if (!second) begin
                if (sb.size() == 0) begin
                    checkOutput("unexpected out_valid", 1, 0);
                    have_exp = 1'b0;
                end else begin
                    cur_exp  = sb.pop_front();
                    have_exp = 1'b1;
                    checkOutput("signal_out", int'($signed(signal_out)), cur_exp.value);
                    checkOutput("sat", int'(sat), cur_exp.sat_flag);
                    checkOutput("latency_ns", int'(longint'($time) - cur_exp.tick_time), 45);
                end
                second = 1'b1;
            end else begin
                if (have_exp) begin
                    checkOutput("signal_out hold", int'($signed(signal_out)), cur_exp.value);
                    checkOutput("sat hold", int'(sat), cur_exp.sat_flag);
                end
                second = 1'b0;
            end
        end else begin
            second = 1'b0;
        end
    end

    int down_exp [4];

    initial begin
        down_exp = '{6143 + RND, 4095 + RND, 2047 + RND, 0};

        // Reset held with enable high and in_valid toggling.
        rst    = 1'b0;
        enable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = ~in_valid;
            @(posedge clk);
            #1;
            checkOutput("reset out_valid", int'(out_valid), 0);
            checkOutput("reset signal_out", int'($signed(signal_out)), 0);
        end
        checkOutput("reset active", int'(active), 0);
        checkOutput("reset settled", int'(settled), 0);
        @(negedge clk);
        in_valid = 1'b0;
        rst      = 1'b1;

        // Snap with ramp_step = 0.
        applyStimulus(16384, 0, 16384, 12345, 1'b1, 0, 8192, 0, 1'b1);
        #1;
        checkOutput("snap settled", int'(settled), 1);
        checkOutput("snap active", int'(active), 1);
        applyStimulus(16384, 0, 16384, 12345, 1'b1, 0, 8192, 0, 1'b1);

        // Saturation, sign and truncation vectors.
        applyStimulus(32767, 32767, 32767, 32767, 1'b1, 0, 32767, 1, 1'b1);
        applyStimulus(-32768, -32768, -32768, -32768, 1'b1, 0, 32767, 1, 1'b1);
        applyStimulus(32767, 32767, -32768, -32768, 1'b1, 0, -32768, 1, 1'b1);
        applyStimulus(-16384, 0, 16384, 0, 1'b1, 0, -8192, 0, 1'b1);
        applyStimulus(8192, 8192, 16384, -8192, 1'b1, 0, 2048, 0, 1'b1);
        applyStimulus(1, 0, -1, 0, 1'b1, 0, -1 + RND, 0, 1'b1);

        // Disable with snap: amplitudes go to zero, output exact 0.
        applyStimulus(12345, -4321, 30000, 20000, 1'b0, 0, 0, 0, 1'b1);
        applyStimulus(12345, -4321, 30000, 20000, 1'b0, 0, 0, 0, 1'b1);
        #1;
        checkOutput("disabled active", int'(active), 0);

        // Ramp 0 -> 8192 in steps of 1024.
        for (int k = 1; k <= 8; k++) begin
            applyStimulus(8192, 0, 32767, 20000, 1'b1, 1024, k * 1024 - 1 + RND, 0, 1'b1);
            #1;
            if (k == 7) checkOutput("ramp settled before target", int'(settled), 0);
            if (k == 8) checkOutput("ramp settled at target", int'(settled), 1);
        end

        // Gap: outputs stop, last value holds, state frozen.
        idle(8);
        checkOutput("gap signal_out hold", int'($signed(signal_out)), 8191 + RND);
        checkOutput("gap out_valid", int'(out_valid), 0);
        checkOutput("gap settled", int'(settled), 1);

        // Ramp down with step 2048.
        for (int k = 0; k < 4; k++) begin
            applyStimulus(8192, 0, 32767, 20000, 1'b0, 2048, down_exp[k], 0, 1'b1);
            #1;
            if (k == 0) begin
                checkOutput("ramp_down settled", int'(settled), 0);
                checkOutput("ramp_down active", int'(active), 1);
            end
            if (k == 3) checkOutput("ramp_down reached off", int'(active), 0);
        end
        applyStimulus(8192, 0, 32767, 20000, 1'b0, 2048, 0, 0, 1'b1);

        // Reset mid-ramp: in-flight samples must vanish.
        applyStimulus(8192, 0, 32767, 0, 1'b1, 1024, 1023 + RND, 0, 1'b1);
        applyStimulus(8192, 0, 32767, 0, 1'b1, 1024, 0, 0, 1'b0);
        applyStimulus(8192, 0, 32767, 0, 1'b1, 1024, 0, 0, 1'b0);
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            checkOutput("mid reset out_valid", int'(out_valid), 0);
        end
        checkOutput("mid reset signal_out", int'($signed(signal_out)), 0);
        checkOutput("mid reset active", int'(active), 0);
        @(negedge clk);
        rst = 1'b1;
        applyStimulus(8192, 0, 32767, 0, 1'b1, 1024, 1023 + RND, 0, 1'b1);
        applyStimulus(8192, 0, 32767, 0, 1'b1, 1024, 2047 + RND, 0, 1'b1);
        applyStimulus(8192, 0, 32767, 0, 1'b1, 1024, 3071 + RND, 0, 1'b1);
        #1;
        checkOutput("restart settled", int'(settled), 0);
        checkOutput("restart active", int'(active), 1);

        idle(2);
        for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
        repeat (4) @(negedge clk);
        checkOutput("scoreboard drained", sb.size(), 0);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
